// File: rtl/led_pkg.sv
// led_pkg: shared mode/state encodings, duty width and duty arithmetic helpers
package led_pkg;
   localparam int DUTY_W = 8;
   typedef logic [DUTY_W-1:0] duty_t;
   typedef enum logic [1:0] {MODE_OFF, MODE_STATIC, MODE_FADE, MODE_BLINK} mode_t;
   typedef enum logic [2:0] {S_OFF, S_STATIC, S_FADE_UP, S_FADE_DOWN, S_BLINK_ON, S_BLINK_OFF} state_t;
   function automatic duty_t expand(input logic [3:0] n);
      return {n, n};
   endfunction
   function automatic duty_t toward(input duty_t d, input duty_t t);
      return d < t ? d + duty_t'(1) : d > t ? d - duty_t'(1) : d;
   endfunction
   function automatic duty_t dec_sat(input duty_t d);
      return d == '0 ? d : d - duty_t'(1);
   endfunction
endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// rgb_fade_sequencer_if: switch panel in, LED drive and duty/busy status out
interface rgb_fade_sequencer_if;
   import led_pkg::*;
   logic [15:0] switchPanel;
   logic rLED, gLED, bLED;
   duty_t duty_r, duty_g, duty_b;
   logic busy;
   modport master(output switchPanel, input rLED, gLED, bLED, duty_r, duty_g, duty_b, busy);
   modport slave(input switchPanel, output rLED, gLED, bLED, duty_r, duty_g, duty_b, busy);
endinterface

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output; duty is latched only at counter wrap so periods never glitch
module pwm_channel import led_pkg::*; (
   input  logic  clk,
   input  logic  rst_n,
   input  duty_t duty,
   input  logic  wrap,
   input  duty_t cnt,
   output logic  pwm
);
   duty_t lat;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) lat <= '0;
      else if (wrap) lat <= duty;
   assign pwm = cnt < lat;
endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: RGB LED controller with off/static/fade/blink modes and shared-counter PWM
module rgb_fade_sequencer import led_pkg::*; #(
   parameter int STEP_CYCLES = 390625,
   parameter int BLINK_STEPS = 128
) (
   input logic clk,
   input logic rst_n,
   rgb_fade_sequencer_if.slave io
);
   localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
   localparam int BW = BLINK_STEPS > 1 ? $clog2(BLINK_STEPS) : 1;
   logic [15:0] s1, s2;
   logic [SW-1:0] sc;
   logic [BW-1:0] bc, bc_n;
   duty_t pc;
   mode_t mode, mode_q;
   state_t st, st_n;
   duty_t [2:0] d, d_n, tgt;
   logic tick, last, unused_bits;
   assign mode = mode_t'(s2[15:14]);
   assign tgt = {expand(s2[11:8]), expand(s2[7:4]), expand(s2[3:0])};
   assign unused_bits = ^s2[13:12];
   assign tick = sc == SW'(STEP_CYCLES - 1);
   assign last = bc == BW'(BLINK_STEPS - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
         sc <= '0;
         pc <= '0;
         st <= S_OFF;
         mode_q <= MODE_OFF;
         d <= '0;
         bc <= '0;
      end else begin
         s1 <= io.switchPanel;
         s2 <= s1;
         sc <= tick ? '0 : sc + SW'(1);
         pc <= pc + duty_t'(1);
         st <= st_n;
         mode_q <= mode;
         d <= d_n;
         bc <= bc_n;
      end
   // a mode change wins over any tick landing on the same cycle
   always_comb begin
      st_n = st;
      d_n = d;
      bc_n = bc;
      if (mode != mode_q) begin
         bc_n = '0;
         st_n = mode == MODE_OFF ? S_OFF : mode == MODE_STATIC ? S_STATIC :
                mode == MODE_FADE ? S_FADE_UP : S_BLINK_ON;
         d_n = mode == MODE_OFF ? '0 : mode == MODE_FADE ? d : tgt;
      end else
         case (st)
            S_OFF: d_n = '0;
            S_STATIC: d_n = tgt;
            S_FADE_UP:
               if (tick) begin
                  for (int i = 0; i < 3; i++) d_n[i] = toward(d[i], tgt[i]);
                  if (d_n == tgt) st_n = S_FADE_DOWN;
               end
            S_FADE_DOWN:
               if (tick) begin
                  for (int i = 0; i < 3; i++) d_n[i] = dec_sat(d[i]);
                  if (d_n == '0) st_n = S_FADE_UP;
               end
            S_BLINK_ON, S_BLINK_OFF: begin
               bc_n = tick ? (last ? '0 : bc + BW'(1)) : bc;
               st_n = (tick && last) ? (st == S_BLINK_ON ? S_BLINK_OFF : S_BLINK_ON) : st;
               d_n = st_n == S_BLINK_ON ? tgt : '0;
            end
            default: st_n = S_OFF;
         endcase
   end
   assign io.busy = st inside {S_FADE_UP, S_FADE_DOWN, S_BLINK_ON, S_BLINK_OFF};
   assign io.duty_r = d[2];
   assign io.duty_g = d[1];
   assign io.duty_b = d[0];
   pwm_channel u_r (.clk(clk), .rst_n(rst_n), .duty(d[2]), .wrap(pc == 8'hFF), .cnt(pc), .pwm(io.rLED));
   pwm_channel u_g (.clk(clk), .rst_n(rst_n), .duty(d[1]), .wrap(pc == 8'hFF), .cnt(pc), .pwm(io.gLED));
   pwm_channel u_b (.clk(clk), .rst_n(rst_n), .duty(d[0]), .wrap(pc == 8'hFF), .cnt(pc), .pwm(io.bLED));
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: directed vector table plus hand-timed fade, blink, PWM and reset sequences
module tb_rgb_fade_sequencer;
   typedef struct {
      int          edge_n;
      logic [15:0] sw;
      logic [7:0]  r, g, b;
      logic        busy;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int tests = 0, fails = 0, edge_cnt = 0;
   rgb_fade_sequencer_if io ();
   rgb_fade_sequencer #(.STEP_CYCLES(4), .BLINK_STEPS(2)) dut (.clk(clk), .rst_n(rst_n), .io(io));
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask
   task automatic check_vec(input vec_t v, input string tag);
      chk({tag, "_r"}, io.duty_r, v.r);
      chk({tag, "_g"}, io.duty_g, v.g);
      chk({tag, "_b"}, io.duty_b, v.b);
      chk({tag, "_busy"}, io.busy, v.busy);
   endtask
   task automatic to_edge(input int n);
      while (edge_cnt < n) begin
         @(posedge clk);
         edge_cnt++;
      end
      #2;
   endtask
   task automatic do_reset(input logic [15:0] sw);
      rst_n = 1'b0;
      io.switchPanel = sw;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      edge_cnt = 0;
   endtask

   vec_t stat [8];
   vec_t fade [13];
   vec_t blink [5];
   int nr, ng, nb;
   initial begin
      stat[0] = '{4, 16'h4F80, 8'hFF, 8'h88, 8'h00, 1'b0};
      stat[1] = '{4, 16'h4123, 8'h11, 8'h22, 8'h33, 1'b0};
      stat[2] = '{4, 16'h7A5C, 8'hAA, 8'h55, 8'hCC, 1'b0};
      stat[3] = '{4, 16'h0FFF, 8'h00, 8'h00, 8'h00, 1'b0};
      stat[4] = '{4, 16'hC123, 8'h11, 8'h22, 8'h33, 1'b1};
      stat[5] = '{4, 16'h3000, 8'h00, 8'h00, 8'h00, 1'b0};
      stat[6] = '{4, 16'h4000, 8'h00, 8'h00, 8'h00, 1'b0};
      stat[7] = '{4, 16'h4F0F, 8'hFF, 8'h00, 8'hFF, 1'b0};
      fade[0]  = '{3,   16'h8210, 8'h00, 8'h00, 8'h00, 1'b1};
      fade[1]  = '{4,   16'h8210, 8'h01, 8'h01, 8'h00, 1'b1};
      fade[2]  = '{7,   16'h8210, 8'h01, 8'h01, 8'h00, 1'b1};
      fade[3]  = '{8,   16'h8210, 8'h02, 8'h02, 8'h00, 1'b1};
      fade[4]  = '{68,  16'h8210, 8'h11, 8'h11, 8'h00, 1'b1};
      fade[5]  = '{72,  16'h8210, 8'h12, 8'h11, 8'h00, 1'b1};
      fade[6]  = '{135, 16'h8210, 8'h21, 8'h11, 8'h00, 1'b1};
      fade[7]  = '{136, 16'h8210, 8'h22, 8'h11, 8'h00, 1'b1};
      fade[8]  = '{140, 16'h8210, 8'h21, 8'h10, 8'h00, 1'b1};
      fade[9]  = '{204, 16'h8210, 8'h11, 8'h00, 8'h00, 1'b1};
      fade[10] = '{271, 16'h8210, 8'h01, 8'h00, 8'h00, 1'b1};
      fade[11] = '{272, 16'h8210, 8'h00, 8'h00, 8'h00, 1'b1};
      fade[12] = '{276, 16'h8210, 8'h01, 8'h01, 8'h00, 1'b1};
      blink[0] = '{3,  16'hCFFF, 8'hFF, 8'hFF, 8'hFF, 1'b1};
      blink[1] = '{7,  16'hCFFF, 8'hFF, 8'hFF, 8'hFF, 1'b1};
      blink[2] = '{8,  16'hCFFF, 8'h00, 8'h00, 8'h00, 1'b1};
      blink[3] = '{15, 16'hCFFF, 8'h00, 8'h00, 8'h00, 1'b1};
      blink[4] = '{16, 16'hCFFF, 8'hFF, 8'hFF, 8'hFF, 1'b1};

      io.switchPanel = 16'hCFFF;
      repeat (2) @(posedge clk);
      #2;
      check_vec('{0, 16'h0, 8'h00, 8'h00, 8'h00, 1'b0}, "reset");
      chk("reset_leds", {io.rLED, io.gLED, io.bLED}, 3'b000);

      do_reset(16'h0000);
      for (int i = 0; i < 8; i++) begin
         io.switchPanel = stat[i].sw;
         to_edge(edge_cnt + stat[i].edge_n);
         check_vec(stat[i], $sformatf("stat%0d", i));
      end

      do_reset(16'h4F80);
      to_edge(3);
      check_vec('{0, 16'h0, 8'hFF, 8'h88, 8'h00, 1'b0}, "stat_3cyc");
      to_edge(300);
      nr = 0; ng = 0; nb = 0;
      for (int i = 0; i < 256; i++) begin
         to_edge(edge_cnt + 1);
         nr += int'(io.rLED);
         ng += int'(io.gLED);
         nb += int'(io.bLED);
      end
      chk("pwm_cnt_r", 16'(nr), 16'd255);
      chk("pwm_cnt_g", 16'(ng), 16'd136);
      chk("pwm_cnt_b", 16'(nb), 16'd0);

      do_reset(16'h8210);
      for (int i = 0; i < 13; i++) begin
         to_edge(fade[i].edge_n);
         check_vec(fade[i], $sformatf("fade@%0d", fade[i].edge_n));
      end

      do_reset(16'hCFFF);
      for (int i = 0; i < 5; i++) begin
         to_edge(blink[i].edge_n);
         check_vec(blink[i], $sformatf("blink@%0d", blink[i].edge_n));
      end
      to_edge(24);
      check_vec('{0, 16'h0, 8'h00, 8'h00, 8'h00, 1'b1}, "blink@24");

      // synchronized mode change lands on edge 20, which is also a step tick
      do_reset(16'h8210);
      to_edge(17);
      io.switchPanel = 16'h0210;
      to_edge(19);
      check_vec('{0, 16'h0, 8'h04, 8'h04, 8'h00, 1'b1}, "chg@19");
      to_edge(20);
      check_vec('{0, 16'h0, 8'h00, 8'h00, 8'h00, 1'b0}, "chg@20");

      do_reset(16'h4800);
      to_edge(255);
      chk("pwm_prelatch", io.rLED, 1'b0);
      to_edge(353);
      io.switchPanel = 16'h4200;
      to_edge(356);
      chk("pwm_duty_new", io.duty_r, 8'h22);
      chk("pwm_cnt100", io.rLED, 1'b1);
      to_edge(391);
      chk("pwm_cnt135", io.rLED, 1'b1);
      to_edge(392);
      chk("pwm_cnt136", io.rLED, 1'b0);
      to_edge(512);
      chk("pwm_new0", io.rLED, 1'b1);
      to_edge(545);
      chk("pwm_new33", io.rLED, 1'b1);
      to_edge(546);
      chk("pwm_new34", io.rLED, 1'b0);

      do_reset(16'h8210);
      to_edge(21);
      chk("mid_r", io.duty_r, 8'h05);
      rst_n = 1'b0;
      #1;
      check_vec('{0, 16'h0, 8'h00, 8'h00, 8'h00, 1'b0}, "async_rst");
      chk("async_leds", {io.rLED, io.gLED, io.bLED}, 3'b000);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      edge_cnt = 0;
      to_edge(3);
      check_vec('{0, 16'h0, 8'h00, 8'h00, 8'h00, 1'b1}, "rerun@3");
      to_edge(4);
      check_vec('{0, 16'h0, 8'h01, 8'h01, 8'h00, 1'b1}, "rerun@4");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rgb_fade_sequencer.md
RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 390625: clock cycles per step tick (about 256 ticks/s at 100 MHz).
REQ-002 SHALL have parameter BLINK_STEPS, default 128: step ticks per blink half-period.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 switchPanel  in  16  [15:14] mode (00 OFF, 01 STATIC, 10 FADE, 11 BLINK); [13:12] unused; [11:8] R, [7:4] G, [3:0] B target nibbles.
REQ-007 rLED, gLED, bLED  out  1 each  PWM drive to the RGB LED, active-high.
REQ-008 duty_r, duty_g, duty_b  out  8 each  current committed duty values.
REQ-009 busy  out  1  high while in FADE_UP, FADE_DOWN, BLINK_ON or BLINK_OFF.

Function
REQ-010 SHALL pass switchPanel through a 2-flop synchronizer; all logic uses only the synchronized value.
REQ-011 SHALL expand each target nibble n to 8 bits as {n,n}, so 0xF becomes 0xFF and 0x0 becomes 0x00.
REQ-012 SHALL generate a one-cycle step tick every STEP_CYCLES cycles from a free-running counter; the counter clears on reset.
REQ-013 SHALL implement states OFF, STATIC, FADE_UP, FADE_DOWN, BLINK_ON and BLINK_OFF.
REQ-014 SHALL respond to a change of synchronized mode on the next cycle: enter the new mode's entry state and clear the blink counter.
- OFF: duties 0.
- STATIC: duties = target.
- FADE: FADE_UP, keeping current duties.
- BLINK: BLINK_ON, duties = target.
REQ-015 In STATIC, duties SHALL track target one cycle after any synchronized target change.
REQ-016 In FADE_UP, on each tick:
- Each channel moves 1 toward its target: +1 if below, -1 if above, unchanged if equal.
- When all three channels equal target after the update, the state goes to FADE_DOWN.
REQ-017 In FADE_DOWN, on each tick:
- Each nonzero channel decrements by 1.
- When all three channels are 0 after the update, the state goes to FADE_UP.
REQ-018 With target all zero in FADE, the state SHALL alternate FADE_UP/FADE_DOWN each tick with duties held at 0.
REQ-019 In BLINK, SHALL toggle between BLINK_ON (duties = live target) and BLINK_OFF (duties 0) after every BLINK_STEPS ticks.
REQ-020 Duty arithmetic SHALL be 8-bit unsigned, never wrapping past 0 or 255.
REQ-021 PWM:
- Uses one shared 8-bit free-running counter.
- An output is high when counter < its latched duty.
- Duty 0 is constant low; duty 255 is high 255 of 256 cycles.
REQ-022 Each PWM channel SHALL latch its duty only when the counter wraps from 255 to 0, giving no mid-period glitches.
REQ-023 A mode change coinciding with a step tick SHALL take priority; that tick's fade/blink update is discarded.

Reset
REQ-024 Reset SHALL asynchronously force:
- state OFF;
- all duties, latched duties and counters to 0;
- rLED, gLED, bLED and busy to 0;
- synchronizer flops to 0.
REQ-025 After reset release, normal operation SHALL begin on the first clock edge, following synchronized switchPanel. Reset mid-fade SHALL discard all progress.

Structure
REQ-026 Mode encodings, state encodings and the 8-bit duty width SHALL live in shared package led_pkg.
REQ-027 PWM generation SHALL be one sub-module, pwm_channel (duty in, wrap strobe in, PWM out), instantiated three times. The PWM counter SHALL live in rgb_fade_sequencer.

Verification
REQ-028 The bench SHALL use STEP_CYCLES=4 and BLINK_STEPS=2.
REQ-029 Scenarios:
- STATIC: switchPanel=0x4F80 -> duties FF/88/00 within 3 cycles; over 256 cycles rLED high 255, gLED high 136, bLED high 0.
- FADE: switchPanel=0x8210 from reset -> duties ramp up 1 per tick; FADE_DOWN entered on the tick duty_r reaches 0x22; all duties 0 after a further 34 ticks, then FADE_UP.
- BLINK: switchPanel=0xCFFF -> duties FF for 2 ticks, 00 for 2 ticks, repeating; busy=1 throughout.
- Mode change: mode switched FADE->OFF on a step-tick cycle -> duties 0 one cycle after the synchronized change; no increment applied.
- PWM glitch-free: duty changed at PWM counter=100 -> output unchanged until the next wrap, new duty applied from counter=0.
- Reset mid-fade: rst_n low during FADE_UP -> all outputs 0 immediately, asynchronously (before the next clk edge); after release, FADE_UP restarts from duty 0.
